// File: rtl/wb_group_scheduler.sv
// Writeback group scheduler: shares one register-file write port among units.
// Optional snoop stage enabled by defining WB_GROUP_SCHEDULER_SNOOP_EN.
module wb_group_scheduler #(
    parameter int NUM_UNITS  = 4,
    parameter int ID_WIDTH   = 3,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_WAIT   = 3,
    localparam int SEL_W     = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1,
    localparam int CNT_W     = $clog2(MAX_WAIT + 1)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_UNITS-1:0]            unit_done,
    input  logic [NUM_UNITS*ID_WIDTH-1:0]   unit_id,
    input  logic [NUM_UNITS*DATA_WIDTH-1:0] unit_rd,
    output logic [NUM_UNITS-1:0]            unit_ack,
    input  logic                            wb_stall,
    output logic                            wb_valid,
    output logic [ID_WIDTH-1:0]             wb_id,
    output logic [DATA_WIDTH-1:0]           wb_data,
    output logic [SEL_W-1:0]                wb_unit_sel,
    output logic                            starve_event
`ifdef WB_GROUP_SCHEDULER_SNOOP_EN
    ,
    output logic                            wb_snoop_valid,
    output logic [ID_WIDTH-1:0]             wb_snoop_id,
    output logic [DATA_WIDTH-1:0]           wb_snoop_data
`endif
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

    logic [NUM_UNITS-1:0]  w_req;
    logic [NUM_UNITS-1:0]  w_promo;
    logic [NUM_UNITS-1:0]  w_ack;
    logic                  w_any_req;
    logic                  w_any_promo;
    logic [SEL_W-1:0]      w_grant;
    logic [ID_WIDTH-1:0]   w_sel_id;
    logic [DATA_WIDTH-1:0] w_sel_data;

    logic [CNT_W-1:0]      r_cnt [NUM_UNITS];
    logic                  r_valid;
    logic [ID_WIDTH-1:0]   r_id;
    logic [DATA_WIDTH-1:0] r_data;
    logic [SEL_W-1:0]      r_sel;
    logic                  r_starve;

    // Stall masks every request; a saturated waiter becomes promoted.
    always_comb begin
        w_req   = wb_stall ? '0 : unit_done;
        w_promo = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            w_promo[i] = w_req[i] && (r_cnt[i] == CNT_MAX);
        end
    end

    // Lowest promoted index wins; otherwise lowest requesting index.
    always_comb begin
        w_grant     = '0;
        w_any_req   = |w_req;
        w_any_promo = |w_promo;
        for (int i = NUM_UNITS - 1; i >= 0; i--) begin
            if (w_any_promo ? w_promo[i] : w_req[i]) begin
                w_grant = SEL_W'(i);
            end
        end
    end

    // One-hot ack, held low during reset; mux the winner's id/data.
    always_comb begin
        w_ack      = '0;
        w_sel_id   = '0;
        w_sel_data = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            w_ack[i] = rst && w_any_req && (w_grant == SEL_W'(i));
            if (w_ack[i]) begin
                w_sel_id   = unit_id[i*ID_WIDTH +: ID_WIDTH];
                w_sel_data = unit_rd[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign unit_ack = w_ack;

    // Age counters: count waiting cycles (stalls included), clear on ack or idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_UNITS; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_UNITS; i++) begin
                if (unit_done[i] && !w_ack[i]) begin
                    if (r_cnt[i] != CNT_MAX) begin
                        r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                    end
                end else begin
                    r_cnt[i] <= '0;
                end
            end
        end
    end

    // Writeback packet register; payload holds when nothing is granted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid  <= 1'b0;
            r_id     <= '0;
            r_data   <= '0;
            r_sel    <= '0;
            r_starve <= 1'b0;
        end else if (|w_ack) begin
            r_valid  <= 1'b1;
            r_id     <= w_sel_id;
            r_data   <= w_sel_data;
            r_sel    <= w_grant;
            r_starve <= w_any_promo;
        end else begin
            r_valid  <= 1'b0;
            r_starve <= 1'b0;
        end
    end

    assign wb_valid     = r_valid;
    assign wb_id        = r_id;
    assign wb_data      = r_data;
    assign wb_unit_sel  = r_sel;
    assign starve_event = r_starve;

`ifdef WB_GROUP_SCHEDULER_SNOOP_EN
    logic                  r_snp_valid;
    logic [ID_WIDTH-1:0]   r_snp_id;
    logic [DATA_WIDTH-1:0] r_snp_data;

    // Writeback delayed one more cycle for load/store forwarding.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_snp_valid <= 1'b0;
            r_snp_id    <= '0;
            r_snp_data  <= '0;
        end else begin
            r_snp_valid <= r_valid;
            r_snp_id    <= r_id;
            r_snp_data  <= r_data;
        end
    end

    assign wb_snoop_valid = r_snp_valid;
    assign wb_snoop_id    = r_snp_id;
    assign wb_snoop_data  = r_snp_data;
`endif

endmodule

// File: tb/tb_wb_group_scheduler.sv
// Testbench for wb_group_scheduler: directed scenarios plus randomized
// traffic against a queue-level reference model.
module tb_wb_group_scheduler;

    localparam int N  = 4;
    localparam int IW = 3;
    localparam int DW = 32;
    localparam int MW = 2;
    localparam int SW = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [N-1:0]    unit_done = '0;
    logic [N*IW-1:0] unit_id = '0;
    logic [N*DW-1:0] unit_rd = '0;
    logic [N-1:0]    unit_ack;
    logic            wb_stall = 1'b0;
    logic            wb_valid;
    logic [IW-1:0]   wb_id;
    logic [DW-1:0]   wb_data;
    logic [SW-1:0]   wb_unit_sel;
    logic            starve_event;
`ifdef WB_GROUP_SCHEDULER_SNOOP_EN
    logic            wb_snoop_valid;
    logic [IW-1:0]   wb_snoop_id;
    logic [DW-1:0]   wb_snoop_data;
`endif

    int checks = 0;
    int errors = 0;

    wb_group_scheduler #(
        .NUM_UNITS (N),
        .ID_WIDTH  (IW),
        .DATA_WIDTH(DW),
        .MAX_WAIT  (MW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .unit_done   (unit_done),
        .unit_id     (unit_id),
        .unit_rd     (unit_rd),
        .unit_ack    (unit_ack),
        .wb_stall    (wb_stall),
        .wb_valid    (wb_valid),
        .wb_id       (wb_id),
        .wb_data     (wb_data),
        .wb_unit_sel (wb_unit_sel),
        .starve_event(starve_event)
`ifdef WB_GROUP_SCHEDULER_SNOOP_EN
        ,
        .wb_snoop_valid(wb_snoop_valid),
        .wb_snoop_id   (wb_snoop_id),
        .wb_snoop_data (wb_snoop_data)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic drive(input logic [N-1:0] d, input logic s);
        @(negedge clk);
        unit_done = d;
        wb_stall  = s;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive('0, 1'b0);
        tick();
    endtask

    task automatic test_reset();
        unit_id[1*IW +: IW] = 3'd1;
        unit_id[3*IW +: IW] = 3'd3;
        drive(4'b1010, 1'b0);
        checks++;
        if (unit_ack !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ack: got %b want 0000", unit_ack);
        end
        checks++;
        if ({wb_valid, wb_id, wb_data, wb_unit_sel, starve_event} !== '0) begin
            errors++;
            $display("FAIL reset_regs: valid=%b id=%0d data=%h sel=%0d st=%b want all 0",
                     wb_valid, wb_id, wb_data, wb_unit_sel, starve_event);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (unit_ack !== 4'b0010) begin
            errors++;
            $display("FAIL reset_first_ack: got %b want 0010", unit_ack);
        end
        tick();
        checks++;
        if (wb_valid !== 1'b1 || wb_unit_sel !== 2'd1) begin
            errors++;
            $display("FAIL reset_first_wb: valid=%b sel=%0d want 1/1", wb_valid, wb_unit_sel);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (unit_ack !== 4'b0000 || wb_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: ack=%b valid=%b want 0000/0", unit_ack, wb_valid);
        end
        tick();
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (unit_ack !== 4'b0010) begin
            errors++;
            $display("FAIL reset_rel_ack1: got %b want 0010", unit_ack);
        end
        tick();
        checks++;
        if (wb_valid !== 1'b1 || wb_unit_sel !== 2'd1 || wb_id !== 3'd1) begin
            errors++;
            $display("FAIL reset_rel_wb1: valid=%b sel=%0d id=%0d want 1/1/1",
                     wb_valid, wb_unit_sel, wb_id);
        end
        drive(4'b1000, 1'b0);
        checks++;
        if (unit_ack !== 4'b1000) begin
            errors++;
            $display("FAIL reset_rel_ack3: got %b want 1000", unit_ack);
        end
        tick();
        checks++;
        if (wb_valid !== 1'b1 || wb_unit_sel !== 2'd3 || wb_id !== 3'd3) begin
            errors++;
            $display("FAIL reset_rel_wb3: valid=%b sel=%0d id=%0d want 1/3/3",
                     wb_valid, wb_unit_sel, wb_id);
        end
        idle();
    endtask

    task automatic test_priority();
        logic [N-1:0] d;
        logic [N-1:0] want_ack;
        logic         want_st [4];
        want_st = '{1'b0, 1'b0, 1'b1, 1'b1};
        d = 4'b1111;
        for (int t = 0; t < 4; t++) begin
            drive(d, 1'b0);
            want_ack = '0;
            want_ack[t] = 1'b1;
            checks++;
            if (unit_ack !== want_ack) begin
                errors++;
                $display("FAIL prio_ack t%0d: got %b want %b", t, unit_ack, want_ack);
            end
            tick();
            checks++;
            if (wb_valid !== 1'b1 || wb_unit_sel !== SW'(t) || starve_event !== want_st[t]) begin
                errors++;
                $display("FAIL prio_wb t%0d: valid=%b sel=%0d st=%b want 1/%0d/%b",
                         t + 1, wb_valid, wb_unit_sel, starve_event, t, want_st[t]);
            end
            d[t] = 1'b0;
        end
        drive('0, 1'b0);
        tick();
        checks++;
        if (wb_valid !== 1'b0) begin
            errors++;
            $display("FAIL prio_end: valid=%b want 0", wb_valid);
        end
    endtask

    task automatic test_single();
        unit_id[3*IW +: IW] = 3'd5;
        unit_rd[3*DW +: DW] = 32'hDEADBEEF;
        drive(4'b1000, 1'b0);
        checks++;
        if (unit_ack !== 4'b1000) begin
            errors++;
            $display("FAIL single_ack: got %b want 1000", unit_ack);
        end
        tick();
        checks++;
        if (wb_valid !== 1'b1 || wb_id !== 3'd5 || wb_data !== 32'hDEADBEEF
            || starve_event !== 1'b0 || wb_unit_sel !== 2'd3) begin
            errors++;
            $display("FAIL single_wb: valid=%b id=%0d data=%h st=%b sel=%0d want 1/5/deadbeef/0/3",
                     wb_valid, wb_id, wb_data, starve_event, wb_unit_sel);
        end
        drive('0, 1'b0);
        tick();
        checks++;
        if (wb_valid !== 1'b0 || wb_id !== 3'd5 || wb_data !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL single_hold: valid=%b id=%0d data=%h want 0/5/deadbeef",
                     wb_valid, wb_id, wb_data);
        end
`ifdef WB_GROUP_SCHEDULER_SNOOP_EN
        checks++;
        if (wb_snoop_valid !== 1'b1 || wb_snoop_id !== 3'd5 || wb_snoop_data !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL snoop_t2: valid=%b id=%0d data=%h want 1/5/deadbeef",
                     wb_snoop_valid, wb_snoop_id, wb_snoop_data);
        end
        drive('0, 1'b0);
        tick();
        checks++;
        if (wb_snoop_valid !== 1'b0) begin
            errors++;
            $display("FAIL snoop_t3: valid=%b want 0", wb_snoop_valid);
        end
`endif
        idle();
    endtask

    task automatic test_stall();
        unit_id[2*IW +: IW] = 3'd6;
        unit_rd[2*DW +: DW] = 32'h1234_5678;
        for (int t = 0; t < 3; t++) begin
            drive(4'b0100, 1'b1);
            checks++;
            if (unit_ack !== 4'b0000) begin
                errors++;
                $display("FAIL stall_ack t%0d: got %b want 0000", t, unit_ack);
            end
            tick();
            checks++;
            if (wb_valid !== 1'b0) begin
                errors++;
                $display("FAIL stall_wb t%0d: valid=%b want 0", t + 1, wb_valid);
            end
        end
        drive(4'b0100, 1'b0);
        checks++;
        if (unit_ack !== 4'b0100) begin
            errors++;
            $display("FAIL stall_rel_ack: got %b want 0100", unit_ack);
        end
        tick();
        checks++;
        if (wb_valid !== 1'b1 || wb_id !== 3'd6 || wb_data !== 32'h1234_5678
            || wb_unit_sel !== 2'd2 || starve_event !== 1'b1) begin
            errors++;
            $display("FAIL stall_rel_wb: valid=%b id=%0d data=%h sel=%0d st=%b want 1/6/12345678/2/1",
                     wb_valid, wb_id, wb_data, wb_unit_sel, starve_event);
        end
        idle();
    endtask

    task automatic test_starvation();
        logic [N-1:0] want [4];
        logic [N-1:0] dv [4];
        want = '{4'b0001, 4'b0001, 4'b0100, 4'b0001};
        dv   = '{4'b0101, 4'b0101, 4'b0101, 4'b0001};
        for (int t = 0; t < 4; t++) begin
            drive(dv[t], 1'b0);
            checks++;
            if (unit_ack !== want[t]) begin
                errors++;
                $display("FAIL starve_ack t%0d: got %b want %b", t, unit_ack, want[t]);
            end
            tick();
            if (t == 2) begin
                checks++;
                if (wb_unit_sel !== 2'd2 || starve_event !== 1'b1) begin
                    errors++;
                    $display("FAIL starve_t3: sel=%0d st=%b want 2/1", wb_unit_sel, starve_event);
                end
            end
            if (t == 3) begin
                checks++;
                if (wb_unit_sel !== 2'd0 || starve_event !== 1'b0) begin
                    errors++;
                    $display("FAIL starve_t4: sel=%0d st=%b want 0/0", wb_unit_sel, starve_event);
                end
            end
        end
        idle();
    endtask

    task automatic test_random();
        bit            pend [N];
        logic [IW-1:0] pid  [N];
        logic [DW-1:0] pdat [N];
        int            waits [N];
        logic [N-1:0]  exp_ack;
        logic          ev;
        logic [IW-1:0] eid;
        logic [DW-1:0] edat;
        int            esel;
        logic          est;
        logic          stall;
        logic          promoted;
        int            g;
        @(negedge clk);
        rst = 1'b0;
        unit_done = '0;
        wb_stall = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        ev = 1'b0; eid = '0; edat = '0; esel = 0; est = 1'b0;
        for (int u = 0; u < N; u++) begin
            pend[u] = 1'b0; waits[u] = 0; pid[u] = '0; pdat[u] = '0;
        end
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            for (int u = 0; u < N; u++) begin
                if (!pend[u] && $urandom_range(1) == 1) begin
                    pend[u] = 1'b1;
                    pid[u]  = IW'($urandom);
                    pdat[u] = $urandom;
                end
                unit_done[u] = pend[u];
                unit_id[u*IW +: IW] = pid[u];
                unit_rd[u*DW +: DW] = pdat[u];
            end
            stall = ($urandom_range(3) == 0);
            wb_stall = stall;
            g = -1;
            if (!stall) begin
                for (int u = 0; u < N; u++)
                    if (g < 0 && pend[u] && waits[u] >= MW) g = u;
                if (g < 0)
                    for (int u = 0; u < N; u++)
                        if (g < 0 && pend[u]) g = u;
            end
            promoted = (g >= 0) && (waits[g] >= MW);
            exp_ack = '0;
            if (g >= 0) exp_ack[g] = 1'b1;
            #1;
            checks++;
            if (unit_ack !== exp_ack) begin
                errors++;
                $display("FAIL rand_ack c%0d: got %b want %b", c, unit_ack, exp_ack);
            end
            tick();
            for (int u = 0; u < N; u++) begin
                if (pend[u] && u != g) waits[u] = (waits[u] + 1 > MW) ? MW : waits[u] + 1;
                else waits[u] = 0;
            end
            if (g >= 0) begin
                ev = 1'b1; eid = pid[g]; edat = pdat[g]; esel = g; est = promoted;
                pend[g] = 1'b0;
            end else begin
                ev = 1'b0; est = 1'b0;
            end
            checks++;
            if (wb_valid !== ev || wb_id !== eid || wb_data !== edat
                || wb_unit_sel !== SW'(esel) || starve_event !== est) begin
                errors++;
                $display("FAIL rand_wb c%0d: got %b/%0d/%h/%0d/%b want %b/%0d/%h/%0d/%b",
                         c, wb_valid, wb_id, wb_data, wb_unit_sel, starve_event,
                         ev, eid, edat, esel, est);
            end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_priority();
        test_single();
        test_stall();
        test_starvation();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_group_scheduler.md
Name: wb_group_scheduler

Overview:
- Schedules one writeback group's shared register-file write port among NUM_UNITS execution units.
- Base arbitration is fixed priority: unit 0, the lowest-latency unit, is highest.
- Per-unit age counters promote any unit that has waited MAX_WAIT cycles, so no unit starves.
- Grant and ack are issued in the same cycle. The winning unit's id/rd is registered onto the writeback packet one cycle later.

Parameters:
- NUM_UNITS, 4, units sharing this group's port (>=1).
- ID_WIDTH, 3, instruction id width.
- DATA_WIDTH, 32, rd data width.
- MAX_WAIT, 3, wait cycles before a requesting unit is promoted (>=1).

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous, active-low reset
- unit_done  input  NUM_UNITS  unit i has a result; held until acked
- unit_id  input  NUM_UNITS*ID_WIDTH  packed ids, unit i at [i*ID_WIDTH +: ID_WIDTH]
- unit_rd  input  NUM_UNITS*DATA_WIDTH  packed result data
- unit_ack  output  NUM_UNITS  one-hot (or zero) acceptance, combinational
- wb_stall  input  1  port unavailable this cycle
- wb_valid  output  1  registered writeback valid
- wb_id  output  ID_WIDTH  registered writeback id
- wb_data  output  DATA_WIDTH  registered writeback data
- wb_unit_sel  output  max(1,$clog2(NUM_UNITS))  index of the unit written back
- starve_event  output  1  registered pulse: current wb was an age promotion

Behaviour:
- Reset (rst=0, async):
  - wb_valid, wb_id, wb_data, wb_unit_sel, starve_event = 0.
  - All age counters = 0.
  - unit_ack is forced to 0 while rst=0.
- Request vector: req = unit_done when wb_stall=0; all-zero when wb_stall=1.
- Promoted set: promo[i] = req[i] & (cnt[i]==MAX_WAIT).
  - If promo is non-zero, grant = lowest set index of promo.
  - Otherwise grant = lowest set index of req.
- unit_ack = one-hot(grant) when any req, else 0. At most one bit is set in any cycle.
- Registered output, one-cycle latency:
  - On any ack: wb_valid<=1, wb_id<=unit_id[grant], wb_data<=unit_rd[grant], wb_unit_sel<=grant, starve_event<=(promo!=0).
  - Otherwise: wb_valid<=0 and starve_event<=0. wb_id, wb_data and wb_unit_sel hold their values.
- Back-to-back: a unit that re-asserts done the cycle after its ack may be granted again. Throughput is one writeback per cycle.
- Age counters, width $clog2(MAX_WAIT+1), per unit, saturating at MAX_WAIT:
  - done[i]=1 and ack[i]=0: cnt[i] <= min(cnt[i]+1, MAX_WAIT). This includes stall cycles.
  - ack[i]=1 or done[i]=0: cnt[i] <= 0.
- Stall: no ack, wb_valid=0 the next cycle. Counters keep aging, so several units can be promoted on release; lowest promoted index wins.
- NUM_UNITS==1: grant is always 0 and wb_unit_sel is constant 0. The counter still exists, but promotion cannot change the winner; starve_event still pulses whenever cnt==MAX_WAIT at grant.
- Protocol checks (bench):
  - A unit must not drop done without ack.
  - unit_id/unit_rd must be stable while done=1 and not acked.

Optional Feature:
- Macro: WB_GROUP_SCHEDULER_SNOOP_EN.
- Defined: adds outputs wb_snoop_valid (1), wb_snoop_id (ID_WIDTH), wb_snoop_data (DATA_WIDTH).
  - These are wb_valid/wb_id/wb_data delayed one further cycle, for load/store forwarding.
  - wb_snoop_valid resets to 0; snoop id/data are reset to 0.
- Undefined: the snoop ports and their registers do not exist; all other behaviour is identical.

Test Plan:
- Reset mid-operation: units 1,3 done, assert rst=0 in cycle 2 → unit_ack=0 and wb_valid=0 immediately. After release, unit 1 is acked first, then unit 3; wb_unit_sel=1 then 3.
- Priority: NUM_UNITS=4, units 0..3 all done at t0, each drops done after its ack → acks 0,1,2,3 in t0..t3. wb_valid=1 in t1..t4 with wb_unit_sel 0,1,2,3, then 0 in t5.
- Single requester: only unit 3 done with id=5, rd=0xDEADBEEF → unit_ack=4'b1000 at t0. At t1: wb_valid=1, wb_id=5, wb_data=0xDEADBEEF, starve_event=0.
- Stall: unit 2 done, wb_stall=1 for t0..t2 → no ack, wb_valid=0 through t3. wb_stall=0 at t3 → ack2 at t3, wb_valid=1 with unit 2's id/rd at t4.
- Starvation, MAX_WAIT=2: unit 0 re-requests every cycle, unit 2 done from t0 → grants 0 (t0), 0 (t1), 2 (t2, promoted), 0 (t3). At t3: wb_unit_sel=2, starve_event=1; starve_event=0 at t4.
- Snoop (macro on): the single-requester stimulus above → wb_snoop_valid=1, wb_snoop_id=5, wb_snoop_data=0xDEADBEEF at t2, then 0 at t3.
